// File: rtl/hb_pkt_parser.sv
// ---------------------------------------------------------------------------
// hb_pkt_parser
// Parses heartbeat packets arriving on a valid/ready word stream and hands
// the accepted cluster-head fields to the known-CH table.
//
// Packet: W0 {type[15:12], rsvd[11:8], round[7:0]}, W1 sender ID, W2 CH ID,
//         W3 hops, W4 QValue, and with HBP_CHECKSUM_EN defined a sixth word
//         W5 = W0^W1^W2^W3^W4.
//
// Ports
//   clk, nrst            clock (rising edge), async active-high reset
//   rx_data/valid/last   input word stream, rx_ready back-pressure
//   my_ID                this node's ID (quasi-static)
//   fCH_ID/Hops/QValue   fields of the last accepted heartbeat
//   en_KCH               1-cycle strobe: fCH_* hold a new heartbeat
//   HB_reset             1-cycle strobe: new round, downstream table clears
//   pkt_drop             1-cycle strobe: packet rejected
//   hb_count             heartbeats emitted in the current round (sat. 255)
//
// Configuration macro: HBP_CHECKSUM_EN (adds the CHK state and W5 check).
// ---------------------------------------------------------------------------
module hb_pkt_parser #(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [WORD_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    input  logic                  rx_last,
    output logic                  rx_ready,
    input  logic [WORD_WIDTH-1:0] my_ID,
    output logic [WORD_WIDTH-1:0] fCH_ID,
    output logic [WORD_WIDTH-1:0] fCH_Hops,
    output logic [WORD_WIDTH-1:0] fCH_QValue,
    output logic                  en_KCH,
    output logic                  HB_reset,
    output logic                  pkt_drop,
    output logic [7:0]            hb_count
);

    // Packet-word states are encoded contiguously from IDLE so that
    // "inside a packet" is a single magnitude compare against ST_LAST.
    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_SRC   = 4'd1;
    localparam logic [3:0] ST_CHID  = 4'd2;
    localparam logic [3:0] ST_HOPS  = 4'd3;
    localparam logic [3:0] ST_QV    = 4'd4;
`ifdef HBP_CHECKSUM_EN
    localparam logic [3:0] ST_CHK   = 4'd5;
    localparam logic [3:0] ST_LAST  = ST_CHK;
`else
    localparam logic [3:0] ST_LAST  = ST_QV;
`endif
    localparam logic [3:0] ST_ROUND = 4'd6;
    localparam logic [3:0] ST_EMIT  = 4'd7;
    localparam logic [3:0] ST_FLUSH = 4'd8;

    localparam logic [WORD_WIDTH-1:0] HOPS_INVALID = {WORD_WIDTH{1'b1}};

`ifdef HBP_CHECKSUM_EN
    // Running XOR checksum step.
    function automatic logic [WORD_WIDTH-1:0] csum_fold(
        input logic [WORD_WIDTH-1:0] acc,
        input logic [WORD_WIDTH-1:0] word
    );
        return acc ^ word;
    endfunction

    logic [WORD_WIDTH-1:0] r_csum;
`endif

    logic [3:0]            r_state;
    logic                  r_rx_ready;
    logic                  r_en_kch;
    logic                  r_hb_reset;
    logic                  r_pkt_drop;
    logic [WORD_WIDTH-1:0] r_fch_id;
    logic [WORD_WIDTH-1:0] r_fch_hops;
    logic [WORD_WIDTH-1:0] r_fch_qv;
    logic [7:0]            r_hb_count;
    logic [7:0]            r_round;
    logic                  r_round_vld;
    logic [7:0]            r_pkt_round;
    logic [WORD_WIDTH-1:0] r_pkt_chid;
    logic [WORD_WIDTH-1:0] r_pkt_hops;
    logic [WORD_WIDTH-1:0] r_pkt_qv;
    logic                  r_bad;

    logic [3:0]            w_next_state;
    logic                  w_xfer;
    logic                  w_in_pkt;
    logic                  w_is_final;
    logic                  w_word_bad;
    logic                  w_bad;
    logic                  w_drop;
    logic                  w_accept;
    logic                  w_new_round;
    logic                  w_cnt_clr;
    logic                  w_cnt_inc;

    // Per-word validity checks and packet outcome decode.
    always_comb begin
        w_xfer     = rx_valid & r_rx_ready;
        w_in_pkt   = (r_state <= ST_LAST);
        w_is_final = (r_state == ST_LAST);
        case (r_state)
            ST_IDLE: w_word_bad = (rx_data[15:12] != 4'h1);
            ST_SRC:  w_word_bad = (rx_data == my_ID);
            ST_HOPS: w_word_bad = (rx_data == HOPS_INVALID);
`ifdef HBP_CHECKSUM_EN
            ST_CHK:  w_word_bad = (rx_data != r_csum);
`endif
            default: w_word_bad = 1'b0;
        endcase
        // W0 starts a fresh packet, so the sticky flag from the last one is ignored.
        if (r_state == ST_IDLE) begin
            w_bad = w_word_bad;
        end else begin
            w_bad = r_bad | w_word_bad;
        end
        w_drop   = 1'b0;
        w_accept = 1'b0;
        if (w_xfer && w_in_pkt) begin
            if (w_is_final) begin
                w_drop   = ~rx_last | w_bad;
                w_accept = rx_last & ~w_bad;
            end else begin
                w_drop   = rx_last;
                w_accept = 1'b0;
            end
        end else begin
            w_drop   = 1'b0;
            w_accept = 1'b0;
        end
        w_new_round = ~r_round_vld | (r_pkt_round != r_round);
        w_cnt_clr   = w_accept & w_new_round;
        w_cnt_inc   = (r_state == ST_ROUND);
    end

    // Next-state logic: one packet state per transferred word.
    always_comb begin
        w_next_state = r_state;
        if (w_in_pkt) begin
            if (w_xfer) begin
                if (w_is_final) begin
                    if (!rx_last) begin
                        w_next_state = ST_FLUSH;
                    end else if (w_bad) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_ROUND;
                    end
                end else if (rx_last) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = r_state + 4'd1;
                end
            end else begin
                w_next_state = r_state;
            end
        end else begin
            case (r_state)
                ST_ROUND: w_next_state = ST_EMIT;
                ST_EMIT:  w_next_state = ST_IDLE;
                ST_FLUSH: begin
                    if (w_xfer && rx_last) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_FLUSH;
                    end
                end
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    // State register, registered ready and the three output strobes.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_state    <= ST_IDLE;
            r_rx_ready <= 1'b0;
            r_pkt_drop <= 1'b0;
            r_hb_reset <= 1'b0;
            r_en_kch   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_rx_ready <= (w_next_state != ST_ROUND) && (w_next_state != ST_EMIT);
            r_pkt_drop <= w_drop;
            r_hb_reset <= w_cnt_clr;
            r_en_kch   <= w_cnt_inc;
        end
    end

    // Capture packet fields and the sticky reject flag as words arrive.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_bad       <= 1'b0;
            r_pkt_round <= 8'h00;
            r_pkt_chid  <= {WORD_WIDTH{1'b0}};
            r_pkt_hops  <= {WORD_WIDTH{1'b0}};
            r_pkt_qv    <= {WORD_WIDTH{1'b0}};
`ifdef HBP_CHECKSUM_EN
            r_csum      <= {WORD_WIDTH{1'b0}};
`endif
        end else if (w_xfer && w_in_pkt) begin
            r_bad <= w_bad;
            case (r_state)
                ST_IDLE: r_pkt_round <= rx_data[7:0];
                ST_CHID: r_pkt_chid  <= rx_data;
                ST_HOPS: r_pkt_hops  <= rx_data;
                ST_QV:   r_pkt_qv    <= rx_data;
                default: r_pkt_qv    <= r_pkt_qv;
            endcase
`ifdef HBP_CHECKSUM_EN
            if (r_state == ST_IDLE) begin
                r_csum <= rx_data;
            end else begin
                r_csum <= csum_fold(r_csum, rx_data);
            end
`endif
        end
    end

    // Round tracking and saturating heartbeat counter.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_round     <= 8'h00;
            r_round_vld <= 1'b0;
            r_hb_count  <= 8'h00;
        end else begin
            if (w_cnt_clr) begin
                r_round     <= r_pkt_round;
                r_round_vld <= 1'b1;
            end
            if (w_cnt_clr && w_cnt_inc) begin
                r_hb_count <= 8'd1;
            end else if (w_cnt_clr) begin
                r_hb_count <= 8'd0;
            end else if (w_cnt_inc && (r_hb_count != 8'hFF)) begin
                r_hb_count <= r_hb_count + 8'd1;
            end
        end
    end

    // Publish the heartbeat fields on the ROUND->EMIT step; held otherwise.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_fch_id   <= {WORD_WIDTH{1'b0}};
            r_fch_hops <= HOPS_INVALID;
            r_fch_qv   <= {WORD_WIDTH{1'b0}};
        end else if (r_state == ST_ROUND) begin
            r_fch_id   <= r_pkt_chid;
            r_fch_hops <= r_pkt_hops;
            r_fch_qv   <= r_pkt_qv;
        end
    end

    assign rx_ready   = r_rx_ready;
    assign pkt_drop   = r_pkt_drop;
    assign HB_reset   = r_hb_reset;
    assign en_KCH     = r_en_kch;
    assign fCH_ID     = r_fch_id;
    assign fCH_Hops   = r_fch_hops;
    assign fCH_QValue = r_fch_qv;
    assign hb_count   = r_hb_count;

endmodule

// File: doc/hb_pkt_parser.md
HB_PKT_PARSER -- requirements
Module: hb_pkt_parser

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16, giving the width of every data/ID/hop/Q field.
REQ-002 SHALL have port clk  in  1  single system clock, rising-edge.
REQ-003 SHALL have port nrst  in  1  reset, asynchronous, active-high (1 = reset asserted).
REQ-004 SHALL have port rx_data  in  WORD_WIDTH  received packet word.
REQ-005 SHALL have port rx_valid  in  1  rx_data valid; a word transfers on a clk edge with rx_valid=1 and rx_ready=1.
REQ-006 SHALL have port rx_last  in  1  marks the final word of a packet; sampled only on transfer.
REQ-007 SHALL have port rx_ready  out  1  parser can accept a word.
REQ-008 SHALL have port my_ID  in  WORD_WIDTH  this node's ID, quasi-static.
REQ-009 SHALL have port fCH_ID, fCH_Hops, fCH_QValue  out  WORD_WIDTH each  fields of the last accepted heartbeat, feeding the known-CH table.
REQ-010 SHALL have port en_KCH  out  1  one-cycle strobe: the fCH_* outputs hold a new heartbeat.
REQ-011 SHALL have port HB_reset  out  1  one-cycle strobe: new round detected, downstream table clears.
REQ-012 SHALL have port pkt_drop  out  1  one-cycle strobe: packet rejected.
REQ-013 SHALL have port hb_count  out  8  heartbeats emitted in the current round.

Function
REQ-014 SHALL parse heartbeat packets of five words: W0 {type[15:12], rsvd[11:8], round[7:0]}, W1 sender ID, W2 CH ID, W3 hops, W4 QValue.
REQ-015 SHALL implement the states IDLE(W0), SRC, CHID, HOPS, QV, CHK (only with the macro), ROUND, EMIT and FLUSH.
REQ-016 SHALL advance exactly one state per transferred word; stalls with rx_valid=0 SHALL hold state.
REQ-017 SHALL drive rx_ready=1 in IDLE, SRC, CHID, HOPS, QV, CHK and FLUSH, and 0 in ROUND and EMIT.
REQ-018 SHALL reject the packet when type != 4'h1, sender == my_ID, hops == 16'hFFFF, or (macro on) the checksum mismatches.
REQ-019 SHALL, on rx_last=1 before the final word, pulse pkt_drop and go to IDLE with no further output.
REQ-020 SHALL, when the final word arrives with rx_last=0, pulse pkt_drop and go to FLUSH, discarding words until a transfer with rx_last=1, then go to IDLE.
REQ-021 SHALL, for any other reject, pulse pkt_drop on the cycle after the final word and return to IDLE; fCH_* SHALL remain unchanged.
REQ-022 SHALL, on an accepted packet, enter ROUND the cycle after the final word; if no round is stored or round differs from the stored round, pulse HB_reset, store round and clear hb_count.
REQ-023 SHALL update fCH_ID/fCH_Hops/fCH_QValue on entering EMIT and pulse en_KCH in EMIT, so en_KCH appears 2 cycles after the final-word transfer; fCH_* SHALL hold until the next accepted packet.
REQ-024 SHALL never assert HB_reset and en_KCH in the same cycle.
REQ-025 SHALL increment hb_count with each en_KCH, saturating at 255; a same-cycle clear and increment SHALL yield 1.

Reset
REQ-026 SHALL, while nrst=1, force state to IDLE, rx_ready, en_KCH, HB_reset and pkt_drop to 0, fCH_ID and fCH_QValue to 16'h0, fCH_Hops to 16'hFFFF, hb_count to 0, and the stored round to invalid.
REQ-027 SHALL abandon a partially received packet on reset without a pulse; after release, the first transferred word SHALL be parsed as W0.

Configuration
REQ-028 SHALL, with HBP_CHECKSUM_EN defined, expect a sixth word W5 = XOR of W0..W4 and reject on mismatch; without it, packets SHALL be five words and the CHK state and checksum logic SHALL be absent.

Verification
REQ-029 SHALL cover: after reset, HB {0x1005, 0x0007, 0x0003, 0x0002, 0x00A0} with my_ID=0x0001 -> HB_reset, then en_KCH, fCH_ID=3, fCH_Hops=2, fCH_QValue=0xA0, hb_count=1.
REQ-030 SHALL cover: a second HB in round 5 from CH 4 -> no HB_reset, en_KCH, fCH_ID=4, hb_count=2.
REQ-031 SHALL cover: sender=my_ID or hops=0xFFFF -> pkt_drop, no en_KCH, fCH_* unchanged.
REQ-032 SHALL cover: rx_last on W2 -> pkt_drop, IDLE; seven words with rx_last only on the seventh -> pkt_drop at W4, flush through the seventh, next packet parsed.
REQ-033 SHALL cover: nrst pulse after W2, then a valid HB -> outputs at reset values, then a normal HB_reset/en_KCH sequence.
REQ-034 SHALL cover, macro on: wrong W5 -> pkt_drop; correct W5 -> en_KCH.
